// File: rtl/hazard_trigger_unit.sv
// Load-use hazard detector with stall/flush controls and a trigger FSM that
// launches one pulse per hazard burst into a downstream two-cycle pulse stage.
module hazard_trigger_unit #(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ifid_valid,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             uses_rt,
   input  logic             idex_mem_read,
   input  logic [4:0]       idex_rt,
   input  logic             branch_taken,
   input  logic             pulse_busy,
   output logic             trigger,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_flush,
   output logic             ifid_flush,
   output logic [CNT_W-1:0] stall_count,
   output logic             busy_timeout
);

   localparam int HW = $clog2(HOLD_MAX + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

   typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;

   state_t        state, state_nxt;
   logic          pending, pending_nxt;
   logic [HW-1:0] hold_cnt, hold_cnt_nxt;
   logic          timeout_nxt;
   logic          hazard;
   logic          stall;

   assign hazard = ifid_valid & idex_mem_read & (idex_rt != 5'd0) &
                   ((idex_rt == ifid_rs) | (uses_rt & (idex_rt == ifid_rt))) &
                   ~branch_taken;

   // Pipeline controls are forced to their pass-through values while in reset.
   assign stall      = hazard & ~rst;
   assign pc_write   = ~stall;
   assign ifid_write = ~stall;
   assign idex_flush = stall;
   assign ifid_flush = branch_taken & ~rst;
   assign trigger    = (state == FIRE);

   always_comb begin
      state_nxt    = state;
      pending_nxt  = pending;
      hold_cnt_nxt = hold_cnt;
      timeout_nxt  = busy_timeout;
      case (state)
         IDLE: begin
            hold_cnt_nxt = '0;
            if ((hazard | pending) & ~pulse_busy) begin
               state_nxt   = FIRE;
               pending_nxt = 1'b0;
            end else if (hazard) begin
               pending_nxt = 1'b1;
            end
         end
         FIRE: begin
            state_nxt    = HOLD;
            hold_cnt_nxt = '0;
            if (hazard) pending_nxt = 1'b1;
         end
         HOLD: begin
            if (hazard) pending_nxt = 1'b1;
            if (~pulse_busy) begin
               state_nxt    = IDLE;
               hold_cnt_nxt = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               // Downstream never released: give up and flag it permanently.
               state_nxt    = IDLE;
               hold_cnt_nxt = '0;
               timeout_nxt  = 1'b1;
            end else begin
               hold_cnt_nxt = hold_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt    = IDLE;
            hold_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         pending      <= 1'b0;
         hold_cnt     <= '0;
         busy_timeout <= 1'b0;
      end else begin
         state        <= state_nxt;
         pending      <= pending_nxt;
         hold_cnt     <= hold_cnt_nxt;
         busy_timeout <= timeout_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= '0;
      end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_trigger_unit.sv
// Directed bench for hazard_trigger_unit: stall/flush decode, trigger FSM,
// pending collapse, HOLD timeout, mid-HOLD reset and stall counter saturation.
module tb_hazard_trigger_unit;

   logic        clk;
   logic        rst;
   logic        ifid_valid;
   logic [4:0]  ifid_rs;
   logic [4:0]  ifid_rt;
   logic        uses_rt;
   logic        idex_mem_read;
   logic [4:0]  idex_rt;
   logic        branch_taken;
   logic        pulse_busy;
   logic        trigger;
   logic        pc_write;
   logic        ifid_write;
   logic        idex_flush;
   logic        ifid_flush;
   logic [15:0] stall_count;
   logic        busy_timeout;

   int n_cmp  = 0;
   int n_fail = 0;

   hazard_trigger_unit #(.HOLD_MAX(8), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .ifid_valid   (ifid_valid),
      .ifid_rs      (ifid_rs),
      .ifid_rt      (ifid_rt),
      .uses_rt      (uses_rt),
      .idex_mem_read(idex_mem_read),
      .idex_rt      (idex_rt),
      .branch_taken (branch_taken),
      .pulse_busy   (pulse_busy),
      .trigger      (trigger),
      .pc_write     (pc_write),
      .ifid_write   (ifid_write),
      .idex_flush   (idex_flush),
      .ifid_flush   (ifid_flush),
      .stall_count  (stall_count),
      .busy_timeout (busy_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic haz(input logic on);
      ifid_valid    = on;
      idex_mem_read = on;
      idex_rt       = 5'd5;
      ifid_rs       = 5'd5;
      ifid_rt       = 5'd0;
      uses_rt       = 1'b0;
   endtask

   initial begin
      rst = 1'b1; branch_taken = 1'b0; pulse_busy = 1'b0;
      haz(1'b1);
      branch_taken = 1'b1;
      #2;
      // reset values with hazard and branch driven
      chk("rst_pc_write", pc_write, 1);
      chk("rst_ifid_write", ifid_write, 1);
      chk("rst_idex_flush", idex_flush, 0);
      chk("rst_ifid_flush", ifid_flush, 0);
      chk("rst_trigger", trigger, 0);
      chk("rst_stall_count", stall_count, 0);
      chk("rst_timeout", busy_timeout, 0);
      tick(); tick();
      chk("rst_stall_hold", stall_count, 0);
      haz(1'b0); branch_taken = 1'b0;
      rst = 1'b0;
      tick();

      // basic load-use hazard
      haz(1'b1);
      #1;
      chk("lu_pc_write", pc_write, 0);
      chk("lu_ifid_write", ifid_write, 0);
      chk("lu_idex_flush", idex_flush, 1);
      chk("lu_trig_t", trigger, 0);
      tick();
      haz(1'b0);
      chk("lu_trig_t1", trigger, 1);
      chk("lu_count", stall_count, 1);
      #1;
      chk("lu_pc_write_rel", pc_write, 1);
      tick();
      chk("lu_trig_t2", trigger, 0);
      tick();

      // rt==0 match is not a hazard
      ifid_valid = 1'b1; idex_mem_read = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
      #1;
      chk("r0_pc_write", pc_write, 1);
      chk("r0_idex_flush", idex_flush, 0);
      tick();
      chk("r0_trig", trigger, 0);
      // rt match ignored unless uses_rt
      idex_rt = 5'd7; ifid_rt = 5'd7; ifid_rs = 5'd3; uses_rt = 1'b0;
      #1;
      chk("nort_pc_write", pc_write, 1);
      tick();
      chk("nort_trig", trigger, 0);
      chk("nort_count", stall_count, 1);
      uses_rt = 1'b1;
      #1;
      chk("rt_pc_write", pc_write, 0);
      chk("rt_idex_flush", idex_flush, 1);
      tick();
      haz(1'b0);
      chk("rt_trig", trigger, 1);
      chk("rt_count", stall_count, 2);
      tick(); tick();

      // branch_taken suppresses hazard
      haz(1'b1); branch_taken = 1'b1;
      #1;
      chk("br_ifid_flush", ifid_flush, 1);
      chk("br_pc_write", pc_write, 1);
      chk("br_idex_flush", idex_flush, 0);
      tick();
      haz(1'b0); branch_taken = 1'b0;
      chk("br_trig", trigger, 0);
      chk("br_count", stall_count, 2);
      #1;
      chk("br_ifid_flush_off", ifid_flush, 0);
      tick();

      // hazard while downstream busy: pending, then fire after release
      pulse_busy = 1'b1; haz(1'b1);
      #1;
      chk("pb_pc_write", pc_write, 0);
      tick();
      haz(1'b0);
      chk("pb_trig_a", trigger, 0);
      tick();
      chk("pb_trig_b", trigger, 0);
      pulse_busy = 1'b0;
      tick();
      chk("pb_trig_fire", trigger, 1);
      chk("pb_count", stall_count, 3);
      pulse_busy = 1'b1;
      tick();
      chk("pb_hold", trigger, 0);
      haz(1'b1);
      tick(); tick(); tick();
      chk("pb_hold3_trig", trigger, 0);
      chk("pb_hold3_count", stall_count, 6);
      haz(1'b0); pulse_busy = 1'b0;
      tick();
      chk("pb_idle_trig", trigger, 0);
      // new hazard coincides with pending: one trigger only
      haz(1'b1);
      tick();
      haz(1'b0);
      chk("pb_extra_trig", trigger, 1);
      chk("pb_extra_count", stall_count, 7);
      tick();
      chk("pb_extra_end", trigger, 0);
      tick(); tick();
      chk("pb_no_second", trigger, 0);
      tick();
      chk("pb_no_second_b", trigger, 0);

      // busy stuck high: HOLD times out after 8 cycles
      haz(1'b1);
      tick();
      haz(1'b0); pulse_busy = 1'b1;
      chk("to_trig", trigger, 1);
      tick();
      repeat (7) tick();
      chk("to_pre_timeout", busy_timeout, 0);
      chk("to_pre_trig", trigger, 0);
      tick();
      chk("to_timeout", busy_timeout, 1);
      pulse_busy = 1'b0; haz(1'b1);
      tick();
      haz(1'b0);
      chk("to_idle_fire", trigger, 1);
      chk("to_count", stall_count, 9);
      tick(); tick();
      chk("to_sticky", busy_timeout, 1);

      // reset in HOLD with pending set
      haz(1'b1);
      tick();
      chk("rh_fire", trigger, 1);
      haz(1'b0); pulse_busy = 1'b1;
      tick();
      haz(1'b1);
      tick();
      rst = 1'b1;
      #1;
      chk("rh_trig", trigger, 0);
      chk("rh_count", stall_count, 0);
      chk("rh_timeout", busy_timeout, 0);
      chk("rh_pc_write", pc_write, 1);
      chk("rh_idex_flush", idex_flush, 0);
      tick();
      haz(1'b0); pulse_busy = 1'b0;
      rst = 1'b0;
      tick();
      chk("rh_post_a", trigger, 0);
      tick();
      chk("rh_post_b", trigger, 0);
      chk("rh_post_count", stall_count, 0);

      // continuous stall saturates the counter
      haz(1'b1);
      repeat (65534) tick();
      chk("sat_fffe", stall_count, 32'hFFFE);
      tick();
      chk("sat_ffff", stall_count, 32'hFFFF);
      tick();
      chk("sat_hold", stall_count, 32'hFFFF);
      haz(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
